// File: rtl/wb_pkg.sv
// Shared constants for the writeback slice, plus the rd-field extractor that decode also uses.
package wb_pkg;
  localparam int WB_DATA_W = 16;
  localparam int WB_NREGS  = 8;
  localparam int WB_AW     = $clog2(WB_NREGS);
  localparam int WB_RD_LSB = 8;

  function automatic logic [WB_AW-1:0] rd_of(input logic [WB_DATA_W-1:0] instr);
    return instr[WB_RD_LSB +: WB_AW];
  endfunction
endpackage

// File: rtl/regfile_2r1w.sv
// NREGS x DATA_W register file: two async read ports, one sync write port, async clear.
module regfile_2r1w #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);
  logic [NREGS-1:0][DATA_W-1:0] mem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  mem        <= '0;
    else if (we) mem[waddr] <= wdata;
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];
endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: registers the memory-stage result, commits it one edge later, and exposes
// bypassed read ports, a forwarding tap, the pending-write scoreboard and a retire counter.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int DATA_W  = WB_DATA_W,
  parameter int ZERO_R0 = 1,
  parameter int CNT_W   = 32,
  localparam int NREGS  = WB_NREGS,
  localparam int AW     = WB_AW,
  localparam int RD_LSB = WB_RD_LSB
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic              mem_iswb,
  input  logic              mem_isld,
  input  logic [DATA_W-1:0] mem_instr,
  input  logic [DATA_W-1:0] mem_aluresult,
  input  logic [DATA_W-1:0] mem_ldresult,
  input  logic              flush,
  input  logic [AW-1:0]     rs1_addr,
  input  logic [AW-1:0]     rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_rd,
  output logic [NREGS-1:0]  busy,
  output logic              fwd_valid,
  output logic [AW-1:0]     fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retired_count
);
  logic              st_v, st_w;
  logic [AW-1:0]     st_rd;
  logic [DATA_W-1:0] st_d;
  logic              commit;
  logic [DATA_W-1:0] rf_rd1, rf_rd2;
  logic [CNT_W-1:0]  cnt_q;
  logic              unused_instr;

  // Only the rd field of the instruction matters here.
  assign unused_instr = ^mem_instr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_v  <= 1'b0;
      st_w  <= 1'b0;
      st_rd <= '0;
      st_d  <= '0;
    end else begin
      st_v  <= mem_valid;
      st_w  <= mem_valid & mem_iswb;
      st_rd <= mem_instr[RD_LSB +: AW];
      st_d  <= mem_isld ? mem_ldresult : mem_aluresult;
    end
  end

  assign fwd_valid = st_v & st_w & ~((ZERO_R0 != 0) && (st_rd == '0));
  assign fwd_rd    = st_rd;
  assign fwd_data  = st_d;
  assign commit    = fwd_valid & ~flush;

  regfile_2r1w #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
    .clk    (clk),
    .reset  (reset),
    .we     (commit),
    .waddr  (st_rd),
    .wdata  (st_d),
    .raddr1 (rs1_addr),
    .raddr2 (rs2_addr),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2)
  );

  always_comb begin
    rs1_data = rf_rd1;
    rs2_data = rf_rd2;
    if (commit && rs1_addr == st_rd) rs1_data = st_d;
    if (commit && rs2_addr == st_rd) rs2_data = st_d;
    if ((ZERO_R0 != 0) && rs1_addr == '0) rs1_data = '0;
    if ((ZERO_R0 != 0) && rs2_addr == '0) rs2_data = '0;
  end

  // Scoreboard: a new issue to a register outranks a same-edge commit to it.
  for (genvar r = 0; r < NREGS; r++) begin : g_sb
    logic set_r, clr_r;
    assign set_r = issue_valid && (issue_rd == AW'(r)) && !((ZERO_R0 != 0) && r == 0);
    assign clr_r = commit && (st_rd == AW'(r));
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)     busy[r] <= 1'b0;
      else if (set_r) busy[r] <= 1'b1;
      else if (clr_r) busy[r] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             cnt_q <= '0;
    else if (st_v && !flush) cnt_q <= cnt_q + CNT_W'(1);
  end
  assign retired_count = cnt_q;
endmodule
